// File: rtl/mla_bus_pkg.sv
// Shared types and constants for the MLA CPU-to-slave bus bridge.
// The optional WAIT timeout is built only when MLA_BRIDGE_TIMEOUT_EN is defined.
package mla_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mla_state_t;

    localparam logic [31:0]  MLA_BUS_ERR_DATA = 32'hDEAD_BEEF;

    localparam int unsigned  MLA_DEF_N_SLV  = 4;
    localparam int unsigned  MLA_ERR_CNT_W  = 8;
    localparam int unsigned  MLA_WAIT_CNT_W = 16;

    // Slave 0 occupies the least-significant 32 bits.
    localparam logic [127:0] MLA_DEF_SLV_BASE = {32'h0000_0000, 32'hFFFF_F060,
                                                 32'hFFFF_F020, 32'hFFFF_F000};
    localparam logic [127:0] MLA_DEF_SLV_MASK = {32'hFFFF_0000, 32'hFFFF_FFE0,
                                                 32'hFFFF_FFE0, 32'hFFFF_FFE0};

    function automatic logic [MLA_ERR_CNT_W-1:0] mla_sat_inc(input logic [MLA_ERR_CNT_W-1:0] v);
        return (v == {MLA_ERR_CNT_W{1'b1}}) ? v : v + MLA_ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/mla_addr_decode.sv
// Combinational priority address decoder: lowest-index matching slave wins.
// Part of the MLA bus bridge (MLA_BRIDGE_TIMEOUT_EN does not affect this block).
module mla_addr_decode
    import mla_bus_pkg::*;
#(
    parameter int unsigned         N_SLV    = MLA_DEF_N_SLV,
    parameter int unsigned         AW       = 32,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = (N_SLV*AW)'(MLA_DEF_SLV_BASE),
    parameter logic [N_SLV*AW-1:0] SLV_MASK = (N_SLV*AW)'(MLA_DEF_SLV_MASK)
) (
    input  logic [AW-1:0]    bus_addr,
    output logic [N_SLV-1:0] hit,
    output logic             hit_any
);

    logic [N_SLV-1:0] w_match;

    always_comb begin
        w_match = '0;
        for (int i = 0; i < N_SLV; i++) begin
            w_match[i] = ((bus_addr & SLV_MASK[i*AW +: AW]) ==
                          (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]));
        end
    end

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        hit = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                hit = N_SLV'(1) << i;
            end
        end
    end

    assign hit_any = |w_match;

endmodule

// File: rtl/mla_bus_bridge.sv
// Single-master bridge from the CPU request/ack bus to N_SLV decoded slaves.
// Define MLA_BRIDGE_TIMEOUT_EN to build the WAIT-state timeout counter.
module mla_bus_bridge
    import mla_bus_pkg::*;
#(
    parameter int unsigned         N_SLV    = MLA_DEF_N_SLV,
    parameter int unsigned         DW       = 32,
    parameter int unsigned         AW       = 32,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = (N_SLV*AW)'(MLA_DEF_SLV_BASE),
    parameter logic [N_SLV*AW-1:0] SLV_MASK = (N_SLV*AW)'(MLA_DEF_SLV_MASK),
    parameter int unsigned         TIMEOUT  = 255
) (
    input  logic                     cpu_clk,
    input  logic                     cpu_rstn,
    input  logic                     bus_req,
    input  logic                     bus_we,
    input  logic [AW-1:0]            bus_addr,
    input  logic [DW-1:0]            bus_wdata,
    output logic [DW-1:0]            bus_rdata,
    output logic                     bus_ack,
    output logic                     bus_err,
    output logic [N_SLV-1:0]         slv_req,
    output logic                     slv_we,
    output logic [AW-1:0]            slv_addr,
    output logic [DW-1:0]            slv_wdata,
    input  logic [N_SLV*DW-1:0]      slv_rdata,
    input  logic [N_SLV-1:0]         slv_ack,
    output logic [MLA_ERR_CNT_W-1:0] err_cnt,
    output logic [AW-1:0]            err_addr
);

    if (N_SLV < 1 || N_SLV > 8) begin : g_bad_n_slv
        $error("mla_bus_bridge: N_SLV must be in 1..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("mla_bus_bridge: TIMEOUT must be in 1..65535");
    end

    mla_state_t               r_state;
    mla_state_t               w_state_nxt;

    logic [N_SLV-1:0]         w_hit;
    logic                     w_hit_any;
    logic                     w_ack_sel;
    logic                     w_timeout;
    logic [DW-1:0]            w_sel_rdata;

    logic [N_SLV-1:0]         r_slv_req,   w_slv_req_nxt;
    logic                     r_slv_we,    w_slv_we_nxt;
    logic [AW-1:0]            r_slv_addr,  w_slv_addr_nxt;
    logic [DW-1:0]            r_slv_wdata, w_slv_wdata_nxt;
    logic                     r_bus_ack,   w_bus_ack_nxt;
    logic                     r_bus_err,   w_bus_err_nxt;
    logic [DW-1:0]            r_bus_rdata, w_bus_rdata_nxt;
    logic [MLA_ERR_CNT_W-1:0] r_err_cnt,   w_err_cnt_nxt;
    logic [AW-1:0]            r_err_addr,  w_err_addr_nxt;
    logic                     w_err_evt;
    logic [AW-1:0]            w_err_evt_addr;

    mla_addr_decode #(
        .N_SLV    (N_SLV),
        .AW       (AW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .bus_addr (bus_addr),
        .hit      (w_hit),
        .hit_any  (w_hit_any)
    );

    // Only the slave currently addressed may complete the access.
    assign w_ack_sel = |(slv_ack & r_slv_req);

    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (r_slv_req[i]) begin
                w_sel_rdata = w_sel_rdata | slv_rdata[i*DW +: DW];
            end
        end
    end

`ifdef MLA_BRIDGE_TIMEOUT_EN
    logic [MLA_WAIT_CNT_W-1:0] r_wait_cnt;
    logic [MLA_WAIT_CNT_W-1:0] w_wait_cnt_nxt;

    // Timeout fires in the TIMEOUT-th WAIT cycle; a same-cycle ack still wins.
    assign w_timeout = (r_wait_cnt == MLA_WAIT_CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_wait_cnt_nxt = r_wait_cnt;
        if (r_state == ST_IDLE && bus_req && w_hit_any) begin
            w_wait_cnt_nxt = '0;
        end else if (r_state == ST_WAIT && !w_ack_sel) begin
            w_wait_cnt_nxt = r_wait_cnt + MLA_WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus_req) begin
                    w_state_nxt = w_hit_any ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (w_ack_sel || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; bus_ack rises on entry to RESP.
    always_comb begin
        w_slv_req_nxt   = r_slv_req;
        w_slv_we_nxt    = r_slv_we;
        w_slv_addr_nxt  = r_slv_addr;
        w_slv_wdata_nxt = r_slv_wdata;
        w_bus_ack_nxt   = 1'b0;
        w_bus_err_nxt   = 1'b0;
        w_bus_rdata_nxt = r_bus_rdata;
        w_err_evt       = 1'b0;
        w_err_evt_addr  = r_slv_addr;
        case (r_state)
            ST_IDLE: begin
                if (bus_req && w_hit_any) begin
                    w_slv_req_nxt   = w_hit;
                    w_slv_we_nxt    = bus_we;
                    w_slv_addr_nxt  = bus_addr;
                    w_slv_wdata_nxt = bus_wdata;
                end else if (bus_req) begin
                    w_bus_ack_nxt   = 1'b1;
                    w_bus_err_nxt   = 1'b1;
                    w_bus_rdata_nxt = DW'(MLA_BUS_ERR_DATA);
                    w_err_evt       = 1'b1;
                    w_err_evt_addr  = bus_addr;
                end
            end
            ST_WAIT: begin
                if (w_ack_sel) begin
                    w_slv_req_nxt   = '0;
                    w_bus_ack_nxt   = 1'b1;
                    w_bus_rdata_nxt = r_slv_we ? '0 : w_sel_rdata;
                end else if (w_timeout) begin
                    w_slv_req_nxt   = '0;
                    w_bus_ack_nxt   = 1'b1;
                    w_bus_err_nxt   = 1'b1;
                    w_bus_rdata_nxt = DW'(MLA_BUS_ERR_DATA);
                    w_err_evt       = 1'b1;
                end
            end
            default: begin
            end
        endcase
        w_err_cnt_nxt  = w_err_evt ? mla_sat_inc(r_err_cnt) : r_err_cnt;
        w_err_addr_nxt = w_err_evt ? w_err_evt_addr : r_err_addr;
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            r_slv_req   <= '0;
            r_slv_we    <= 1'b0;
            r_slv_addr  <= '0;
            r_slv_wdata <= '0;
            r_bus_ack   <= 1'b0;
            r_bus_err   <= 1'b0;
            r_bus_rdata <= '0;
            r_err_cnt   <= '0;
            r_err_addr  <= '0;
        end else begin
            r_slv_req   <= w_slv_req_nxt;
            r_slv_we    <= w_slv_we_nxt;
            r_slv_addr  <= w_slv_addr_nxt;
            r_slv_wdata <= w_slv_wdata_nxt;
            r_bus_ack   <= w_bus_ack_nxt;
            r_bus_err   <= w_bus_err_nxt;
            r_bus_rdata <= w_bus_rdata_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_err_addr  <= w_err_addr_nxt;
        end
    end

    assign slv_req   = r_slv_req;
    assign slv_we    = r_slv_we;
    assign slv_addr  = r_slv_addr;
    assign slv_wdata = r_slv_wdata;
    assign bus_ack   = r_bus_ack;
    assign bus_err   = r_bus_err;
    assign bus_rdata = r_bus_rdata;
    assign err_cnt   = r_err_cnt;
    assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_mla_bus_bridge.sv
// Self-checking bench for mla_bus_bridge: directed and random accesses against a reference model.
// Timeout checks apply when MLA_BRIDGE_TIMEOUT_EN is defined; otherwise long waits must persist.
module tb_mla_bus_bridge;

    localparam int T = 3;
`ifdef MLA_BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [31:0] M_BASE [4] = '{32'hFFFF_F000, 32'hFFFF_F020, 32'hFFFF_F060, 32'h0000_0000};
    localparam logic [31:0] M_MASK [4] = '{32'hFFFF_FFE0, 32'hFFFF_FFE0, 32'hFFFF_FFE0, 32'hFFFF_0000};
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rstn;
    logic         bus_req;
    logic         bus_we;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic [31:0]  bus_rdata;
    logic         bus_ack;
    logic         bus_err;
    logic [3:0]   slv_req;
    logic         slv_we;
    logic [31:0]  slv_addr;
    logic [31:0]  slv_wdata;
    logic [127:0] slv_rdata;
    logic [3:0]   slv_ack;
    logic [7:0]   err_cnt;
    logic [31:0]  err_addr;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           m_err_cnt = 0;
    logic [31:0]  m_err_addr = '0;

    always #5 clk = ~clk;

    mla_bus_bridge #(.TIMEOUT(T)) dut (
        .cpu_clk   (clk),
        .cpu_rstn  (rstn),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err),
        .slv_req   (slv_req),
        .slv_we    (slv_we),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_rdata (slv_rdata),
        .slv_ack   (slv_ack),
        .err_cnt   (err_cnt),
        .err_addr  (err_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if ((a & M_MASK[i]) == (M_BASE[i] & M_MASK[i])) return i;
        end
        return -1;
    endfunction

    // One full CPU transaction, called and returning at a falling edge.
    // ack_at: WAIT cycle (0-based) in which the addressed slave acks; -1 = never.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input int ack_at, input logic [31:0] rd);
        int          s;
        int          exp_lat;
        int          cyc;
        bit          got;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [3:0]  exp_req;
        logic [3:0]  junk;
        s       = ref_decode(addr);
        exp_req = (s >= 0) ? 4'(1 << s) : 4'b0000;
        if (s < 0) begin
            exp_lat = 1; exp_err = 1'b1; exp_rd = ERR_DATA;
        end else if (TO_EN && (ack_at < 0 || ack_at >= T)) begin
            exp_lat = T + 1; exp_err = 1'b1; exp_rd = ERR_DATA;
        end else begin
            exp_lat = 2 + ack_at; exp_err = 1'b0; exp_rd = we ? 32'h0 : rd;
        end
        if (exp_err) begin
            m_err_cnt  = (m_err_cnt < 255) ? m_err_cnt + 1 : 255;
            m_err_addr = addr;
        end
        bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 60) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus_ack === 1'b1) begin
                got = 1'b1;
                chk("latency", 32'(cyc), 32'(exp_lat));
                chk("bus_err", 32'(bus_err), 32'(exp_err));
                chk("bus_rdata", bus_rdata, exp_rd);
                chk("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
                chk("err_addr", err_addr, m_err_addr);
                chk("slv_req_resp", 32'(slv_req), 32'h0);
                bus_req = 1'b0;
            end else begin
                chk("slv_req_wait", 32'(slv_req), 32'(exp_req));
                if (cyc == 1) begin
                    chk("slv_we", 32'(slv_we), 32'(we));
                    chk("slv_addr", slv_addr, addr);
                    chk("slv_wdata", slv_wdata, wdata);
                end
                junk = 4'($urandom) & ~exp_req;
                if (s >= 0 && (cyc - 1) == ack_at) junk = junk | exp_req;
                slv_ack   = junk;
                slv_rdata = {$urandom, $urandom, $urandom, $urandom};
                if (s >= 0) slv_rdata[s*32 +: 32] = rd;
            end
        end
        chk("ack_seen", 32'(got), 32'h1);
        slv_ack = 4'b0000;
        bus_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ack_pulse", 32'(bus_ack), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        logic [31:0] a;
        rstn = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        slv_rdata = '0; slv_ack = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_ack", 32'(bus_ack), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_bus_rdata", bus_rdata, 32'h0);
        chk("rst_slv_req", 32'(slv_req), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        rstn = 1'b1;
        @(negedge clk);

        run_access(1'b0, 32'hFFFF_F000, 32'h0, 0, 32'h0000_1234);
        run_access(1'b1, 32'hFFFF_F024, 32'h0000_00A5, 5, 32'h5555_AAAA);
        run_access(1'b0, 32'h8000_0000, 32'h0, 0, 32'h0);
        chk("miss_err_cnt", 32'(err_cnt), 32'h1);
        chk("miss_err_addr", err_addr, 32'h8000_0000);
        run_access(1'b0, 32'hFFFF_F064, 32'h0, TO_EN ? -1 : 12, 32'h7777_0001);
        run_access(1'b0, 32'hFFFF_F068, 32'h0, T - 1, 32'h7777_0002);
        run_access(1'b0, 32'h0000_1230, 32'h0, 1, 32'h3333_4444);

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 4);
            if (k == 4) begin
                a = $urandom;
                while (ref_decode(a) >= 0) a = $urandom;
            end else begin
                a = M_BASE[k] | ($urandom & ~M_MASK[k]);
            end
            run_access(1'($urandom), a, $urandom, $urandom_range(0, 5), $urandom);
        end

        // Reset while a write is waiting on its slave.
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 32'hFFFF_F004; bus_wdata = 32'hCAFE_0001;
        @(posedge clk); @(negedge clk);
        chk("rw_slv_req", 32'(slv_req), 32'h1);
        @(posedge clk); @(negedge clk);
        rstn = 1'b0; bus_req = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rw_slv_req_clr", 32'(slv_req), 32'h0);
        chk("rw_bus_ack", 32'(bus_ack), 32'h0);
        chk("rw_slv_we", 32'(slv_we), 32'h0);
        chk("rw_slv_addr", slv_addr, 32'h0);
        chk("rw_slv_wdata", slv_wdata, 32'h0);
        chk("rw_err_cnt", 32'(err_cnt), 32'h0);
        chk("rw_err_addr", err_addr, 32'h0);
        m_err_cnt = 0; m_err_addr = '0;
        rstn = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); @(negedge clk);
            chk("rw_no_ack", 32'(bus_ack), 32'h0);
        end

        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            while (ref_decode(a) >= 0) a = $urandom;
            run_access(1'($urandom), a, $urandom, 0, 32'h0);
        end
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
